cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per source skid FIFO; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state.
REQ-005 flush  input  1  mispredict flush; discards all buffered results.
REQ-006 alu_valid  input  1  ALU result valid this cycle.
REQ-007 alu_lab  input  ROB_ID_WIDTH+1  ROB label of the ALU result.
REQ-008 alu_val  input  VAL_WIDTH  ALU result value.
REQ-009 lsb_valid  input  1  load/store buffer result valid.
REQ-010 lsb_lab  input  ROB_ID_WIDTH+1  ROB label of the LSB result.
REQ-011 lsb_val  input  VAL_WIDTH  LSB result value.
REQ-012 alu_full  output  1  ALU FIFO full; ALU must not present a result.
REQ-013 lsb_full  output  1  LSB FIFO full.
REQ-014 cdb_en  output  1  broadcast valid, registered.
REQ-015 cdb_lab  output  ROB_ID_WIDTH+1  broadcast label, registered.
REQ-016 cdb_val  output  VAL_WIDTH  broadcast value, registered.
REQ-017 cdb_src  output  1  source of the current broadcast: 0 = ALU, 1 = LSB.
REQ-018 ovf_err  output  1  sticky flag; set when a push is dropped because its FIFO is full.

Function
REQ-019 There SHALL be one circular FIFO per source, each with a read pointer, a write pointer and a count that wrap modulo FIFO_DEPTH.
REQ-020 Push: on a posedge with rdy_in=1, flush=0, src_valid=1, src_lab!=0 and count<FIFO_DEPTH, the FIFO SHALL store {lab,val}.
REQ-021 A push with label 0 SHALL be ignored, because label 0 means "no label".
REQ-022 src_full SHALL be the combinational result of count==FIFO_DEPTH, ignoring any pop in the same cycle; a push while full SHALL be dropped and SHALL set ovf_err.
REQ-023 Arbitration: on each posedge with rdy_in=1 and flush=0, if any FIFO is non-empty, exactly one head SHALL be popped and registered onto cdb_lab/cdb_val/cdb_src, with cdb_en=1.
REQ-024 Arbitration: if both FIFOs are empty on such a posedge, cdb_en SHALL become 0, and cdb_lab/cdb_val SHALL become 0.
REQ-025 Push and pop on the same FIFO in one cycle SHALL both take effect, leaving count unchanged.
REQ-026 A pushed entry SHALL reach the CDB no earlier than the posedge after the one that captured it, giving a minimum latency of 1 cycle; the arbiter has no combinational bypass.
REQ-027 Winner selection with CDB_RR_EN is defined in REQ-034.
REQ-028 After a flush, selection SHALL start from the ALU.
REQ-029 Flush on a posedge with rdy_in=1: counts and pointers SHALL go to 0, cdb_en to 0 and last_grant to LSB, so the ALU is favoured next; pushes in that cycle SHALL be discarded.
REQ-030 When rdy_in=0, every register, including the cdb_* outputs, SHALL hold its value, and no push or pop SHALL occur.
REQ-031 Within one source, results SHALL leave in the order they were pushed.

Reset
REQ-032 rst_in=1 at a posedge SHALL clear FIFOs, pointers and counts, and SHALL set cdb_en=0, cdb_lab=0, cdb_val=0, cdb_src=0 and ovf_err=0, with last_grant set to LSB.
REQ-033 Reset SHALL take priority over flush and rdy_in; a reset arriving while a FIFO is partly full SHALL discard its contents.

Configuration
REQ-034 With macro CDB_RR_EN defined, arbitration SHALL be round-robin: when both FIFOs are non-empty, the source not granted last SHALL win, and a single non-empty FIFO SHALL always win.
REQ-035 Without CDB_RR_EN, arbitration SHALL be fixed priority with the ALU always winning, and the last_grant register SHALL be absent.

Verification
REQ-036 Reset, then a single ALU push of lab=3, val=0x10 at cycle N -> cdb_en=1, cdb_lab=3, cdb_val=0x10, cdb_src=0 after posedge N+1, and cdb_en=0 after N+2.
REQ-037 With CDB_RR_EN, push ALU labs 1 and 2 and LSB labs 5 and 6 on the same two cycles -> broadcast order 1, 5, 2, 6; without the macro -> order 1, 2, 5, 6.
REQ-038 With pops blocked, hold alu_valid for 5 cycles with FIFO_DEPTH=4 -> alu_full=1 after 4 pushes, the fifth push dropped, ovf_err=1 and held until reset.
REQ-039 With 3 entries buffered, assert flush for one cycle -> cdb_en=0 the next cycle, counts 0, and none of the 3 labels ever appear on the CDB.
REQ-040 Drive rdy_in=0 for 3 cycles while cdb_en=1 with lab=7 and both FIFOs non-empty -> outputs hold lab=7 and counts are unchanged; arbitration resumes on the first cycle with rdy_in=1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and load/store-buffer results onto a single common
// data bus. Each source feeds a small circular skid FIFO; one head is popped
// per enabled cycle and broadcast from registered cdb_* outputs.
//
// Build option: define CDB_RR_EN for round-robin arbitration between the two
// FIFOs (last_grant register present). Without it the ALU has fixed priority.
//
// Ports:
//   clk, rst_in         clock, synchronous active-high reset
//   rdy_in              global enable; low freezes every register
//   flush               discards all buffered results
//   alu_valid/lab/val   ALU result input (label 0 = no result)
//   lsb_valid/lab/val   LSB result input (label 0 = no result)
//   alu_full, lsb_full  combinational FIFO-full indications
//   cdb_en/lab/val/src  registered broadcast (src: 0 = ALU, 1 = LSB)
//   ovf_err             sticky: a push was dropped because its FIFO was full
module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter int unsigned VAL_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  alu_valid,
  input  logic [ROB_ID_WIDTH:0] alu_lab,
  input  logic [VAL_WIDTH-1:0]  alu_val,
  input  logic                  lsb_valid,
  input  logic [ROB_ID_WIDTH:0] lsb_lab,
  input  logic [VAL_WIDTH-1:0]  lsb_val,
  output logic                  alu_full,
  output logic                  lsb_full,
  output logic                  cdb_en,
  output logic [ROB_ID_WIDTH:0] cdb_lab,
  output logic [VAL_WIDTH-1:0]  cdb_val,
  output logic                  cdb_src,
  output logic                  ovf_err
);

  localparam int unsigned LAB_W = ROB_ID_WIDTH + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NSRC  = 2;
  localparam logic        SRC_LSB = 1'b1;

  typedef struct packed {
    logic [LAB_W-1:0]     lab;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  // Index 0 is the ALU FIFO, index 1 the LSB FIFO.
  entry_t           mem    [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NSRC];
  logic [PTR_W-1:0] wr_ptr [NSRC];
  logic [CNT_W-1:0] cnt    [NSRC];

  entry_t            in_ent   [NSRC];
  logic              in_valid [NSRC];
  logic [NSRC-1:0]   full;
  logic [NSRC-1:0]   empty;
  logic [NSRC-1:0]   push_req;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic              sel;
  logic              any_ready;
  logic              drop;

`ifdef CDB_RR_EN
  logic              last_grant;
`endif

  // Push qualification, full/empty flags and winner selection.
  always_comb begin
    in_valid[0]   = alu_valid;
    in_ent[0].lab = alu_lab;
    in_ent[0].val = alu_val;
    in_valid[1]   = lsb_valid;
    in_ent[1].lab = lsb_lab;
    in_ent[1].val = lsb_val;
    full     = '0;
    empty    = '0;
    push_req = '0;
    push     = '0;
    pop      = '0;
    sel      = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      full[i]     = (cnt[i] == CNT_W'(FIFO_DEPTH));
      empty[i]    = (cnt[i] == '0);
      // Label 0 means "no label", so it never counts as a push attempt.
      push_req[i] = rdy_in && !flush && in_valid[i] && (in_ent[i].lab != '0);
      // Full ignores a same-cycle pop: a push into a full FIFO is dropped.
      push[i]     = push_req[i] && !full[i];
    end
    drop      = |(push_req & full);
    any_ready = |(~empty);
`ifdef CDB_RR_EN
    // Both pending: favour the source not granted last time.
    if (!empty[0] && !empty[1]) sel = ~last_grant;
    else                        sel = empty[0];
`else
    sel = empty[0];
`endif
    if (rdy_in && !flush && any_ready) pop[sel] = 1'b1;
    alu_full = full[0];
    lsb_full = full[1];
  end

  // FIFO storage; stale entries after reset/flush are unreachable via pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!rst_in && push[i]) mem[i][wr_ptr[i]] <= in_ent[i];
    end
  end

  // Pointers, counts, broadcast registers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      cdb_en  <= 1'b0;
      cdb_lab <= '0;
      cdb_val <= '0;
      cdb_src <= 1'b0;
      ovf_err <= 1'b0;
`ifdef CDB_RR_EN
      last_grant <= SRC_LSB;
`endif
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < NSRC; i++) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          cnt[i]    <= '0;
        end
        cdb_en <= 1'b0;
`ifdef CDB_RR_EN
        last_grant <= SRC_LSB;
`endif
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        if (any_ready) begin
          cdb_en  <= 1'b1;
          cdb_lab <= mem[sel][rd_ptr[sel]].lab;
          cdb_val <= mem[sel][rd_ptr[sel]].val;
          cdb_src <= sel;
`ifdef CDB_RR_EN
          last_grant <= sel;
`endif
        end else begin
          cdb_en  <= 1'b0;
          cdb_lab <= '0;
          cdb_val <= '0;
        end
        if (drop) ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: queue-based reference model plus a decoupled
// monitor that scoreboards every broadcast the DUT presents.
module tb_cdb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned LW    = RW + 1;
  localparam int unsigned VW    = 32;

  localparam int K_NONE  = 0;
  localparam int K_RST   = 1;
  localparam int K_HOLD  = 2;
  localparam int K_FLUSH = 3;
  localparam int K_IDLE  = 4;
  localparam int K_BCAST = 5;

  logic          clk;
  logic          rst_in, rdy_in, flush;
  logic          alu_valid, lsb_valid;
  logic [LW-1:0] alu_lab, lsb_lab, cdb_lab;
  logic [VW-1:0] alu_val, lsb_val, cdb_val;
  logic          alu_full, lsb_full, cdb_en, cdb_src, ovf_err;

  typedef struct {
    logic [LW-1:0] lab;
    logic [VW-1:0] val;
    logic          src;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  ent_t exp_q[$];
  logic m_ovf  = 1'b0;
  int   m_kind = K_NONE;
`ifdef CDB_RR_EN
  logic m_last = 1'b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .ROB_ID_WIDTH(RW),
    .VAL_WIDTH   (VW)
  ) dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush    (flush),
    .alu_valid(alu_valid),
    .alu_lab  (alu_lab),
    .alu_val  (alu_val),
    .lsb_valid(lsb_valid),
    .lsb_lab  (lsb_lab),
    .lsb_val  (lsb_val),
    .alu_full (alu_full),
    .lsb_full (lsb_full),
    .cdb_en   (cdb_en),
    .cdb_lab  (cdb_lab),
    .cdb_val  (cdb_val),
    .cdb_src  (cdb_src),
    .ovf_err  (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour for the coming edge, from the current inputs and queues.
  task automatic model_step();
    int   sa, sb;
    ent_t e;
    logic win;
    if (rst_in) begin
      qa.delete(); qb.delete(); m_ovf = 1'b0; m_kind = K_RST;
`ifdef CDB_RR_EN
      m_last = 1'b1;
`endif
      return;
    end
    if (!rdy_in) begin
      m_kind = K_HOLD;
      return;
    end
    if (flush) begin
      qa.delete(); qb.delete(); m_kind = K_FLUSH;
`ifdef CDB_RR_EN
      m_last = 1'b1;
`endif
      return;
    end
    sa = qa.size();
    sb = qb.size();
    if (sa + sb > 0) begin
`ifdef CDB_RR_EN
      if (sa > 0 && sb > 0) win = ~m_last;
      else                  win = (sa == 0);
      m_last = win;
`else
      win = (sa == 0);
`endif
      if (!win) e = qa.pop_front();
      else      e = qb.pop_front();
      e.src = win;
      exp_q.push_back(e);
      m_kind = K_BCAST;
    end else begin
      m_kind = K_IDLE;
    end
    if (alu_valid && alu_lab != '0) begin
      if (sa == DEPTH) m_ovf = 1'b1;
      else begin e.lab = alu_lab; e.val = alu_val; e.src = 1'b0; qa.push_back(e); end
    end
    if (lsb_valid && lsb_lab != '0) begin
      if (sb == DEPTH) m_ovf = 1'b1;
      else begin e.lab = lsb_lab; e.val = lsb_val; e.src = 1'b1; qb.push_back(e); end
    end
  endtask

  task automatic cyc(input logic r, input logic rd, input logic fl,
                     input logic av, input logic [LW-1:0] al, input logic [VW-1:0] avl,
                     input logic bv, input logic [LW-1:0] bl, input logic [VW-1:0] bvl);
    @(negedge clk);
    rst_in = r; rdy_in = rd; flush = fl;
    alu_valid = av; alu_lab = al; alu_val = avl;
    lsb_valid = bv; lsb_lab = bl; lsb_val = bvl;
    #1;
    chk("alu_full", alu_full, qa.size() == DEPTH);
    chk("lsb_full", lsb_full, qb.size() == DEPTH);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: scoreboards each new broadcast and checks idle/hold/reset behaviour.
  initial begin
    logic          p_en, p_src;
    logic [LW-1:0] p_lab;
    logic [VW-1:0] p_val;
    ent_t          e;
    p_en = 1'b0; p_src = 1'b0; p_lab = '0; p_val = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_kind != K_NONE) begin
        case (m_kind)
          K_RST: begin
            chk("rst_en", cdb_en, 1'b0);
            chk("rst_lab", cdb_lab, '0);
            chk("rst_val", cdb_val, '0);
            chk("rst_src", cdb_src, 1'b0);
          end
          K_HOLD: begin
            chk("hold_en", cdb_en, p_en);
            chk("hold_lab", cdb_lab, p_lab);
            chk("hold_val", cdb_val, p_val);
            chk("hold_src", cdb_src, p_src);
          end
          K_FLUSH: chk("flush_en", cdb_en, 1'b0);
          K_IDLE: begin
            chk("idle_en", cdb_en, 1'b0);
            chk("idle_lab", cdb_lab, '0);
            chk("idle_val", cdb_val, '0);
          end
          default: chk("bcast_en", cdb_en, 1'b1);
        endcase
        if (cdb_en && m_kind != K_HOLD) begin
          if (exp_q.size() == 0) chk("unexpected_bcast_lab", cdb_lab, '0);
          else begin
            e = exp_q.pop_front();
            chk("bcast_lab", cdb_lab, e.lab);
            chk("bcast_val", cdb_val, e.val);
            chk("bcast_src", cdb_src, e.src);
          end
        end
        chk("ovf_err", ovf_err, m_ovf);
      end
      p_en = cdb_en; p_lab = cdb_lab; p_val = cdb_val; p_src = cdb_src;
    end
  end

  // Stimulus.
  initial begin
    logic          r, rd, fl, av, bv;
    logic [LW-1:0] al, bl;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_lab = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_lab = '0; lsb_val = '0;

    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    // Single ALU result: one-cycle latency then idle.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(3), VW'(32'h10), 1'b0, '0, '0);
    idle(3);

    // Two ALU and two LSB results on the same two cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(1), VW'(32'h101), 1'b1, LW'(5), VW'(32'h505));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(2), VW'(32'h202), 1'b1, LW'(6), VW'(32'h606));
    idle(5);

    // Sustained pushes from both sources: a FIFO fills, pushes drop, ovf_err sticks.
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(i + 1), VW'(32'hA00 + i),
          1'b1, LW'(i + 16), VW'(32'hB00 + i));
    // Label 0 is ignored even when valid.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0, VW'(32'hDEAD), 1'b1, '0, VW'(32'hBEEF));
    // Flush with results buffered; pushes in the flush cycle are discarded.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, LW'(20), VW'(32'hF0), 1'b1, LW'(21), VW'(32'hF1));
    idle(3);

    // Freeze with both FIFOs non-empty and a broadcast on the bus.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(7), VW'(32'h77), 1'b1, LW'(8), VW'(32'h88));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(9), VW'(32'h99), 1'b1, LW'(10), VW'(32'hAA));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, LW'(11), VW'(32'hBB), 1'b1, LW'(12), VW'(32'hCC));
    idle(8);

    // Reset clears the sticky flag and any buffered content.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, LW'(13), VW'(32'h13), 1'b1, LW'(14), VW'(32'h14));
    cyc(1'b1, 1'b0, 1'b1, 1'b1, LW'(15), VW'(32'h15), 1'b0, '0, '0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 39) == 0);
      av = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 2) != 0);
      al = LW'($urandom_range(0, 31));
      bl = LW'($urandom_range(0, 31));
      cyc(r, rd, fl, av, al, VW'($urandom), bv, bl, VW'($urandom));
    end
    idle(12);

    @(posedge clk);
    #2;
    m_kind = K_NONE;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
